// File: rtl/conv_patch_feeder_if.sv
// Pixel-in / patch-out handshake bundle for conv_patch_feeder.
// master = the feeder itself, slave = the surrounding producer/consumer side.
interface conv_patch_feeder_if #(
    parameter int IMG_W    = 28,
    parameter int K        = 3,
    parameter int IN_WIDTH = 8
);
    localparam int OUT_W = IMG_W - K + 1;

    logic                                    i_pix_valid;
    logic                                    o_pix_ready;
    logic [IN_WIDTH-1:0]                     i_pix;
    logic                                    o_post_valid;
    logic                                    i_post_ready;
    logic [OUT_W-1:0][K*K-1:0][IN_WIDTH-1:0] o_patch;
    logic                                    o_last;

    modport master (
        input  i_pix_valid, i_pix, i_post_ready,
        output o_pix_ready, o_post_valid, o_patch, o_last
    );

    modport slave (
        output i_pix_valid, i_pix, i_post_ready,
        input  o_pix_ready, o_post_valid, o_patch, o_last
    );
endinterface

// File: rtl/conv_patch_feeder.sv
// Frame-buffered feeder: stores a raster image, then emits one row of KxK patches per beat.
// Optional overlap of loading and emission is enabled by defining FEED_EARLY_START_EN.
module conv_patch_feeder #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 3,
    parameter int IN_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    conv_patch_feeder_if.master  bus
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int PIX_W = $clog2(N_PIX);
    localparam int ROW_W = $clog2(IMG_H + K + 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(N_PIX - 1);
    localparam logic [ROW_W-1:0] LAST_BEAT = ROW_W'(OUT_H - 1);

    logic [IN_WIDTH-1:0]                     r_fb [N_PIX];
    logic [PIX_W-1:0]                        r_pix_cnt;
    logic [ROW_W-1:0]                        r_beat_idx;
    logic                                    w_pix_ready;
    logic                                    w_post_valid;
    logic                                    w_pix_fire;
    logic                                    w_post_fire;
    logic [OUT_W-1:0][K*K-1:0][IN_WIDTH-1:0] w_patch;

    function automatic logic [PIX_W-1:0] fb_addr(input logic [ROW_W-1:0] row_base,
                                                 input int ky, input int col);
        return PIX_W'((int'(row_base) + ky) * IMG_W + col);
    endfunction

    assign w_pix_fire       = bus.i_pix_valid & w_pix_ready;
    assign w_post_fire      = w_post_valid & bus.i_post_ready;
    assign bus.o_pix_ready  = w_pix_ready;
    assign bus.o_post_valid = w_post_valid;
    assign bus.o_last       = w_post_valid & (r_beat_idx == LAST_BEAT);
    assign bus.o_patch      = w_patch;

    // Frame buffer write port; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (w_pix_fire) begin
            r_fb[r_pix_cnt] <= bus.i_pix;
        end
    end

    // Pixel write address and beat index, both wrapping at end of frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_cnt  <= {PIX_W{1'b0}};
            r_beat_idx <= {ROW_W{1'b0}};
        end else begin
            if (w_pix_fire) begin
                r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? {PIX_W{1'b0}} : r_pix_cnt + PIX_W'(1);
            end
            if (w_post_fire) begin
                r_beat_idx <= (r_beat_idx == LAST_BEAT) ? {ROW_W{1'b0}} : r_beat_idx + ROW_W'(1);
            end
        end
    end

    // Patch gather: element ky*K+kx of patch c is pixel (beat_idx+ky, c+kx)
    always_comb begin
        w_patch = {(OUT_W*K*K*IN_WIDTH){1'b0}};
        for (int c = 0; c < OUT_W; c++) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    w_patch[c][ky*K+kx] = r_fb[fb_addr(r_beat_idx, ky, c + kx)];
                end
            end
        end
    end

`ifdef FEED_EARLY_START_EN
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_rows_done;
    logic             r_pix_done;
    logic             r_beats_done;
    logic             w_pix_done_nx;
    logic             w_beats_done_nx;

    assign w_pix_done_nx   = r_pix_done | (w_pix_fire & (r_pix_cnt == LAST_PIX));
    assign w_beats_done_nx = r_beats_done | (w_post_fire & (r_beat_idx == LAST_BEAT));
    assign w_pix_ready     = ~i_rst & ~r_pix_done;
    // A beat may go once its bottom kernel row is fully loaded
    assign w_post_valid    = ~i_rst & ~r_beats_done & ((r_beat_idx + ROW_W'(K)) <= r_rows_done);

    // Row-completion tracking; frame closes when all pixels are in and all beats are out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col        <= {COL_W{1'b0}};
            r_rows_done  <= {ROW_W{1'b0}};
            r_pix_done   <= 1'b0;
            r_beats_done <= 1'b0;
        end else if (w_pix_done_nx & w_beats_done_nx) begin
            r_col        <= {COL_W{1'b0}};
            r_rows_done  <= {ROW_W{1'b0}};
            r_pix_done   <= 1'b0;
            r_beats_done <= 1'b0;
        end else begin
            r_pix_done   <= w_pix_done_nx;
            r_beats_done <= w_beats_done_nx;
            if (w_pix_fire) begin
                if (r_col == LAST_COL) begin
                    r_col       <= {COL_W{1'b0}};
                    r_rows_done <= r_rows_done + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end
`else
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Strict alternation: load a whole frame, then emit all beats
    always_comb begin
        w_state_nx   = r_state;
        w_pix_ready  = 1'b0;
        w_post_valid = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_pix_ready = ~i_rst;
                if (bus.i_pix_valid && (r_pix_cnt == LAST_PIX)) begin
                    w_state_nx = ST_EMIT;
                end else begin
                    w_state_nx = ST_LOAD;
                end
            end
            ST_EMIT: begin
                w_post_valid = ~i_rst;
                if (bus.i_post_ready && (r_beat_idx == LAST_BEAT)) begin
                    w_state_nx = ST_LOAD;
                end else begin
                    w_state_nx = ST_EMIT;
                end
            end
            default: begin
                w_state_nx = ST_LOAD;
            end
        endcase
    end
`endif
endmodule

// File: doc/conv_patch_feeder.md
Name: conv_patch_feeder

Overview:
Upstream producer for the conv/fc pipeline. Accepts a raster-order 8-bit image stream and stores it in an internal frame buffer. Emits one output row of 3x3 patches per beat, 26 patches x 9 elements, over a valid/ready handshake that drives the conv stage's pre-side (i_pre_valid/o_pre_ready/i_conv_kernel). One image produces 26 beats, in the same order the fc stage steps its weight-chunk counter (beat r = output positions 26r..26r+25).

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 3, square kernel size
IN_WIDTH, 8, pixel width
OUT_W (localparam), IMG_W-K+1 = 26, patches per beat
OUT_H (localparam), IMG_H-K+1 = 26, beats per frame

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_pix_valid  in  1  pixel stream valid
o_pix_ready  out  1  pixel stream ready
i_pix  in  IN_WIDTH  pixel, raster order (row-major, x fastest)
o_post_valid  out  1  patch beat valid (to conv i_pre_valid)
i_post_ready  in  1  patch beat ready (from conv o_pre_ready)
o_patch  out  IN_WIDTH x [OUT_W][K*K]  patch array (to conv i_conv_kernel)
o_last  out  1  high with o_post_valid on final beat (r = OUT_H-1)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. While i_rst is high: o_pix_ready=0, o_post_valid=0, o_last=0, all counters 0, state=LOAD. Frame buffer contents are not reset.
- pix fire = i_pix_valid & o_pix_ready. post fire = o_post_valid & i_post_ready.
- Counters: pix_cnt 0..IMG_W*IMG_H-1 (write address), beat_idx 0..OUT_H-1.
- Patch mapping: o_patch[c][ky*K+kx] = pixel(row beat_idx+ky, col c+kx). Element order matches conv weight order [0][k].
- o_patch is combinational from the frame buffer and beat_idx. It must be stable while o_post_valid & !i_post_ready.
- States:
  - LOAD: o_pix_ready=1, o_post_valid=0. Each pix fire writes buffer[pix_cnt] and increments pix_cnt. Fire on the last pixel (pix_cnt=IMG_W*IMG_H-1) sets pix_cnt to 0 and goes to EMIT. o_post_valid is 1 on the next cycle.
  - EMIT: o_pix_ready=0, o_post_valid=1. Each post fire increments beat_idx. Post fire at beat_idx=OUT_H-1 sets beat_idx to 0 and goes to LOAD. o_pix_ready is 1 on the next cycle.
- o_last = o_post_valid & (beat_idx==OUT_H-1).
- No beat is dropped or repeated under any valid/ready pattern. i_post_ready held low stalls indefinitely.
- Reset mid-frame (any state) abandons the frame. The next frame starts at pixel 0, beat 0.
- Width: pixels are passed through unmodified. No arithmetic on data.

Optional Feature:
Macro FEED_EARLY_START_EN.
- Defined:
  - Emission overlaps loading. rows_done = number of complete image rows loaded in the current frame.
  - o_post_valid = (beat_idx+K <= rows_done) & beats remain in the frame.
  - o_pix_ready=1 until all IMG_W*IMG_H pixels of the frame are accepted, independent of emission.
  - The next frame's pixels are not accepted until the final beat of the current frame has fired. The frame ends when both conditions hold, and o_pix_ready rises the cycle after.
  - First valid comes the cycle after pixel index K*IMG_W-1 (83) is accepted.
- Undefined: strict LOAD/EMIT alternation as above.
- Data ordering and content are identical in both modes.

Test Plan:
1. Ramp frame pix[y*28+x]=(y*28+x)&8'hFF, i_pix_valid=1, i_post_ready=1.
   - Exactly 26 beats.
   - Beat 0 patch 0 = {0,1,2,28,29,30,56,57,58}.
   - Beat 25 patch 25 elem 8 = 783&8'hFF = 15.
   - o_last only on beat 25.
   - First o_post_valid is 1 cycle after the pixel-783 fire.
2. Same frame, i_post_ready low for 5 cycles during beat 3, then random 50%.
   - o_patch and o_last hold stable while stalled.
   - 26 fires total, identical data to scenario 1.
3. i_pix_valid random 50% gaps.
   - Frame-buffer contents and all 26 beats identical to scenario 1.
4. Two back-to-back frames, second frame = ramp+1.
   - o_pix_ready=0 throughout EMIT of frame 1.
   - Frame 2 beat 0 patch 0 = {1,2,3,29,30,31,57,58,59}.
5. Assert i_rst for 1 cycle after beat 10 fires.
   - Next cycle o_post_valid=0, o_pix_ready=1.
   - A fresh ramp frame yields the scenario-1 output from beat 0.
6. FEED_EARLY_START_EN defined, continuous pixels, sink always ready.
   - o_post_valid first high the cycle after pixel 83 fires.
   - Beat r fires no earlier than the cycle after pixel (r+3)*28-1 fires.
   - Data matches scenario 1.
